// File: rtl/coin_return_dispenser.sv
// Change payout engine: captures the owed balance and ejects one coin per
// cycle, largest denomination first, limited by the per-coin stock counters.
module coin_return_dispenser #(
    parameter int kNumCoins  = 3,
    parameter int kTotalBits = 31,
    parameter int COIN_VAL0  = 100,
    parameter int COIN_VAL1  = 500,
    parameter int COIN_VAL2  = 1000,
    parameter int STOCK_BITS = 8,
    parameter int INIT_STOCK = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_return_req,
    input  logic [kTotalBits-1:0] i_total,
    input  logic [kNumCoins-1:0]  i_input_coin,
    output logic                  o_busy,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic                  o_done,
    output logic [kTotalBits-1:0] o_change_left,
    output logic [STOCK_BITS-1:0] o_stock0,
    output logic [STOCK_BITS-1:0] o_stock1,
    output logic [STOCK_BITS-1:0] o_stock2
);

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } state_t;

    localparam logic [kTotalBits-1:0] COIN_VAL [kNumCoins] = '{
        kTotalBits'(COIN_VAL0),
        kTotalBits'(COIN_VAL1),
        kTotalBits'(COIN_VAL2)
    };
    localparam logic [STOCK_BITS-1:0] STOCK_MAX  = '1;
    localparam logic [STOCK_BITS-1:0] STOCK_INIT = STOCK_BITS'(INIT_STOCK);

    state_t                  state;
    state_t                  state_nx;
    logic [kTotalBits-1:0]   remain;
    logic [kTotalBits-1:0]   remain_nx;
    logic [kTotalBits-1:0]   change_left_nx;
    logic [kTotalBits-1:0]   sel_val;
    logic [kNumCoins-1:0]    pick;
    logic [kNumCoins-1:0]    coin_nx;
    logic                    done_nx;
    logic [STOCK_BITS-1:0]   stock    [kNumCoins];
    logic [STOCK_BITS-1:0]   stock_nx [kNumCoins];

    // Ascending scan: the last match is the largest payable denomination.
    always_comb begin
        pick    = '0;
        sel_val = '0;
        if (state == DISPENSE) begin
            for (int c = 0; c < kNumCoins; c++) begin
                if (COIN_VAL[c] <= remain && stock[c] != '0) begin
                    pick    = kNumCoins'(1) << c;
                    sel_val = COIN_VAL[c];
                end
            end
        end
    end

    // Insert and eject of the same coin in one cycle cancel out.
    always_comb begin
        for (int c = 0; c < kNumCoins; c++) begin
            stock_nx[c] = stock[c];
            unique case ({i_input_coin[c], pick[c]})
                2'b10: begin
                    if (stock[c] != STOCK_MAX) begin
                        stock_nx[c] = stock[c] + 1'b1;
                    end
                end
                2'b01: stock_nx[c] = stock[c] - 1'b1;
                default: stock_nx[c] = stock[c];
            endcase
        end
    end

    always_comb begin
        state_nx       = state;
        remain_nx      = remain;
        coin_nx        = '0;
        done_nx        = 1'b0;
        change_left_nx = o_change_left;
        unique case (state)
            IDLE: begin
                if (i_return_req) begin
                    remain_nx = i_total;
                    state_nx  = DISPENSE;
                end
            end
            DISPENSE: begin
                if (|pick) begin
                    coin_nx   = pick;
                    remain_nx = remain - sel_val;
                end else begin
                    change_left_nx = remain;
                    done_nx        = 1'b1;
                    state_nx       = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            remain        <= '0;
            o_return_coin <= '0;
            o_done        <= 1'b0;
            o_change_left <= '0;
            for (int c = 0; c < kNumCoins; c++) begin
                stock[c] <= STOCK_INIT;
            end
        end else begin
            state         <= state_nx;
            remain        <= remain_nx;
            o_return_coin <= coin_nx;
            o_done        <= done_nx;
            o_change_left <= change_left_nx;
            for (int c = 0; c < kNumCoins; c++) begin
                stock[c] <= stock_nx[c];
            end
        end
    end

    assign o_busy   = (state != IDLE);
    assign o_stock0 = stock[0];
    assign o_stock1 = stock[1];
    assign o_stock2 = stock[2];

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for coin_return_dispenser: directed payouts with literal expectations
// plus randomized traffic checked every cycle against a greedy payout model.
module tb_coin_return_dispenser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_return_req = 1'b0;
    logic [30:0] i_total = '0;
    logic [2:0]  i_input_coin = '0;
    logic        o_busy;
    logic [2:0]  o_return_coin;
    logic        o_done;
    logic [30:0] o_change_left;
    logic [7:0]  o_stock0;
    logic [7:0]  o_stock1;
    logic [7:0]  o_stock2;

    coin_return_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .i_return_req (i_return_req),
        .i_total      (i_total),
        .i_input_coin (i_input_coin),
        .o_busy       (o_busy),
        .o_return_coin(o_return_coin),
        .o_done       (o_done),
        .o_change_left(o_change_left),
        .o_stock0     (o_stock0),
        .o_stock1     (o_stock1),
        .o_stock2     (o_stock2)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: payout phase plus remaining amount, greedy pick by value.
    int     val [3] = '{100, 500, 1000};
    bit     m_paying;
    bit     m_finishing;
    longint m_remain;
    longint m_left;
    int     m_stock [3];
    int     m_coin;
    bit     m_done;

    task automatic model_step();
        int sel;
        int d;
        if (reset) begin
            m_paying = 0; m_finishing = 0; m_remain = 0; m_left = 0;
            m_coin = 0; m_done = 0;
            for (int c = 0; c < 3; c++) m_stock[c] = 10;
            return;
        end
        sel = -1;
        if (m_paying) begin
            for (int c = 2; c >= 0; c--) begin
                if (sel < 0 && val[c] <= m_remain && m_stock[c] > 0) sel = c;
            end
        end
        for (int c = 0; c < 3; c++) begin
            d = int'(i_input_coin[c]) - ((sel == c) ? 1 : 0);
            if (d > 0) m_stock[c] = (m_stock[c] < 255) ? m_stock[c] + 1 : 255;
            else if (d < 0) m_stock[c] = m_stock[c] - 1;
        end
        m_coin = 0;
        m_done = 0;
        if (m_finishing) begin
            m_finishing = 0;
        end else if (m_paying) begin
            if (sel >= 0) begin
                m_coin = 1 << sel;
                m_remain = m_remain - val[sel];
            end else begin
                m_left = m_remain;
                m_done = 1;
                m_paying = 0;
                m_finishing = 1;
            end
        end else if (i_return_req) begin
            m_remain = longint'(i_total);
            m_paying = 1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("coin", o_return_coin, m_coin);
            chk("done", o_done, m_done);
            chk("busy", o_busy, m_paying || m_finishing);
            chk("change_left", o_change_left, m_left);
            chk("stock0", o_stock0, m_stock[0]);
            chk("stock1", o_stock1, m_stock[1]);
            chk("stock2", o_stock2, m_stock[2]);
            chk("onehot", $onehot0(o_return_coin), 1);
        end
    end

    task automatic cyc(input logic r, input logic q, input int t,
                       input logic [2:0] ic);
        @(negedge clk);
        reset = r;
        i_return_req = q;
        i_total = 31'(t);
        i_input_coin = ic;
        @(posedge clk);
        model_step();
        #1;
    endtask

    logic [2:0] got [$];
    logic [2:0] expq [$];
    int         got_cycles;
    bit         got_done;
    longint     got_left;

    task automatic pay(input int t);
        got.delete();
        got_cycles = 0;
        got_done = 0;
        got_left = -1;
        cyc(0, 1, t, 0);
        for (int i = 0; i < 60 && !got_done; i++) begin
            cyc(0, 0, 0, 0);
            got_cycles++;
            if (o_return_coin != 0) got.push_back(o_return_coin);
            if (o_done) begin
                got_done = 1;
                got_left = longint'(o_change_left);
            end
        end
        chk("payout_done_seen", got_done, 1);
        cyc(0, 0, 0, 0);
    endtask

    task automatic check_seq(input string name);
        chk({name, "_ncoins"}, got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            chk({name, "_coin"}, got[i], expq[i]);
        end
    endtask

    task automatic chk_stocks(input string name, input int s0, input int s1,
                              input int s2);
        chk({name, "_s0"}, o_stock0, s0);
        chk({name, "_s1"}, o_stock1, s1);
        chk({name, "_s2"}, o_stock2, s2);
    endtask

    initial begin
        cyc(1, 0, 0, 0);
        chk_en = 1'b1;
        cyc(1, 0, 0, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_coin", o_return_coin, 0);
        chk("rst_done", o_done, 0);
        chk("rst_left", o_change_left, 0);
        chk_stocks("rst", 10, 10, 10);

        pay(1600);
        expq = '{3'b100, 3'b010, 3'b001};
        check_seq("p1600");
        chk("p1600_left", got_left, 0);
        chk("p1600_cycles", got_cycles, 4);
        chk_stocks("p1600", 9, 9, 9);

        pay(2750);
        expq = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b001};
        check_seq("p2750");
        chk("p2750_left", got_left, 50);
        chk_stocks("p2750", 7, 8, 7);

        pay(7000);
        chk("p7000_ncoins", got.size(), 7);
        chk("p7000_left", got_left, 0);
        chk_stocks("p7000", 7, 8, 0);

        pay(1000);
        expq = '{3'b010, 3'b010};
        check_seq("p1000");
        chk("p1000_left", got_left, 0);

        pay(16000);
        chk("p16000_ncoins", got.size(), 13);
        chk("p16000_left", got_left, 12300);
        chk_stocks("p16000", 0, 0, 0);

        pay(300);
        chk("empty_ncoins", got.size(), 0);
        chk("empty_left", got_left, 300);
        chk("empty_cycles", got_cycles, 1);

        pay(0);
        chk("zero_left", got_left, 0);
        chk("zero_cycles", got_cycles, 1);

        // Second request and an inserted 100 while a 100 is being ejected.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1600, 0);
        cyc(0, 0, 0, 0);
        chk("ign_c1", o_return_coin, 3'b100);
        cyc(0, 0, 0, 0);
        chk("ign_c2", o_return_coin, 3'b010);
        cyc(0, 1, 500, 3'b001);
        chk("ign_c3", o_return_coin, 3'b001);
        chk("ign_s0_net", o_stock0, 10);
        cyc(0, 0, 0, 0);
        chk("ign_done", o_done, 1);
        chk("ign_left", o_change_left, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("ign_idle", o_busy, 0);
        chk_stocks("ign", 10, 9, 9);

        // Reset on the second dispense cycle aborts without a done pulse.
        cyc(0, 1, 1600, 0);
        cyc(0, 0, 0, 0);
        chk("abort_c1", o_return_coin, 3'b100);
        cyc(1, 0, 0, 0);
        chk("abort_coin", o_return_coin, 0);
        chk("abort_busy", o_busy, 0);
        chk_stocks("abort", 10, 10, 10);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk("abort_nodone", o_done, 0);
        end

        for (int i = 0; i < 250; i++) cyc(0, 0, 0, 3'b111);
        chk_stocks("sat", 255, 255, 255);

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 149) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) * 100
                                            : int'($urandom_range(0, 20000)),
                ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
        end

        cyc(0, 0, 0, 0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
